addsub_arbiter: RTL and testbench

//  Shares one combinational addsub32 unit between two requesters (N=0,1).

---
 rtl/addsub_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_addsub_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Purpose: round-robin share of one combinational addsub32 unit between two requesters, one op in flight.
// Latency: grant cycle T, operands on au_* in T+1, registered response valid from T+2; 1 op per 3 clk.
// Backpressure: response held until rsp_ready; no grants outside IDLE. Option: ARB_FIXED_PRIO_EN (r0 wins ties).
module addsub_arbiter #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [31:0]      r0_a,
    input  logic [31:0]      r0_b,
    input  logic [1:0]       r0_aluc,
    input  logic [TAG_W-1:0] r0_tag,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [31:0]      r1_a,
    input  logic [31:0]      r1_b,
    input  logic [1:0]       r1_aluc,
    input  logic [TAG_W-1:0] r1_tag,
    output logic [31:0]      au_a,
    output logic [31:0]      au_b,
    output logic [1:0]       au_aluc,
    input  logic [31:0]      au_c,
    input  logic             au_overflow,
    input  logic             au_carry,
    input  logic             au_negative,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_c,
    output logic             rsp_overflow,
    output logic             rsp_carry,
    output logic             rsp_negative,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [1:0]       op_aluc_q, op_aluc_d;
    logic [TAG_W-1:0] op_tag_q, op_tag_d;
    logic             op_id_q, op_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [31:0]      rsp_c_q, rsp_c_d;
    logic             rsp_ov_q, rsp_ov_d;
    logic             rsp_cy_q, rsp_cy_d;
    logic             rsp_ng_q, rsp_ng_d;
    logic             busy_q, busy_d;
    logic             prio;
    logic             gnt0, gnt1;

`ifdef ARB_FIXED_PRIO_EN
    // Requester 0 always wins a tie; no priority state exists.
    assign prio = 1'b0;
`else
    logic             prio_q, prio_d;
    assign prio = prio_q;
`endif

    // Grant only while idle: a lone requester wins, a tie goes to prio.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == S_IDLE) begin
            if (r0_valid && r1_valid) begin
                gnt0 = ~prio;
                gnt1 = prio;
            end else begin
                gnt0 = r0_valid;
                gnt1 = r1_valid;
            end
        end
    end

    // Next-state: latch winner's op, capture unit result in EXEC, drain in RESP.
    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_aluc_d   = op_aluc_q;
        op_tag_d    = op_tag_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_c_d     = rsp_c_q;
        rsp_ov_d    = rsp_ov_q;
        rsp_cy_d    = rsp_cy_q;
        rsp_ng_d    = rsp_ng_q;
`ifndef ARB_FIXED_PRIO_EN
        prio_d      = prio_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (gnt0 || gnt1) begin
                    state_d   = S_EXEC;
                    op_a_d    = gnt1 ? r1_a    : r0_a;
                    op_b_d    = gnt1 ? r1_b    : r0_b;
                    op_aluc_d = gnt1 ? r1_aluc : r0_aluc;
                    op_tag_d  = gnt1 ? r1_tag  : r0_tag;
                    op_id_d   = gnt1;
`ifndef ARB_FIXED_PRIO_EN
                    // Loser of this contest is favoured next time.
                    prio_d    = ~gnt1;
`endif
                end
            end
            S_EXEC: begin
                state_d     = S_RESP;
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_tag_d   = op_tag_q;
                rsp_c_d     = au_c;
                rsp_ov_d    = au_overflow;
                rsp_cy_d    = au_carry;
                rsp_ng_d    = au_negative;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_aluc_q   <= '0;
            op_tag_q    <= '0;
            op_id_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_c_q     <= '0;
            rsp_ov_q    <= 1'b0;
            rsp_cy_q    <= 1'b0;
            rsp_ng_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            prio_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_aluc_q   <= op_aluc_d;
            op_tag_q    <= op_tag_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_c_q     <= rsp_c_d;
            rsp_ov_q    <= rsp_ov_d;
            rsp_cy_q    <= rsp_cy_d;
            rsp_ng_q    <= rsp_ng_d;
            busy_q      <= busy_d;
`ifndef ARB_FIXED_PRIO_EN
            prio_q      <= prio_d;
`endif
        end
    end

    assign r0_ready     = gnt0;
    assign r1_ready     = gnt1;
    // Op registers feed the unit directly so au_* stay quiet between ops.
    assign au_a         = op_a_q;
    assign au_b         = op_b_q;
    assign au_aluc      = op_aluc_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_tag      = rsp_tag_q;
    assign rsp_c        = rsp_c_q;
    assign rsp_overflow = rsp_ov_q;
    assign rsp_carry    = rsp_cy_q;
    assign rsp_negative = rsp_ng_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Purpose: bench for addsub_arbiter with an emulated addsub32 unit and a transaction-level model.
// Latency: checks grant/response timing every cycle against the model.
// Backpressure: exercises rsp_ready held low and the handshake cycle.
module tb_addsub_arbiter;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             r0_valid, r0_ready, r1_valid, r1_ready;
    logic [31:0]      r0_a, r0_b, r1_a, r1_b;
    logic [1:0]       r0_aluc, r1_aluc;
    logic [TAG_W-1:0] r0_tag, r1_tag;
    logic [31:0]      au_a, au_b, au_c;
    logic [1:0]       au_aluc;
    logic             au_overflow, au_carry, au_negative;
    logic             rsp_valid, rsp_ready, rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_c;
    logic             rsp_overflow, rsp_carry, rsp_negative, busy;

    int checks = 0;
    int failures = 0;
    bit en = 0;

    addsub_arbiter #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_aluc(r0_aluc), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_aluc(r1_aluc), .r1_tag(r1_tag),
        .au_a(au_a), .au_b(au_b), .au_aluc(au_aluc), .au_c(au_c),
        .au_overflow(au_overflow), .au_carry(au_carry), .au_negative(au_negative),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_c(rsp_c), .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
        .rsp_negative(rsp_negative), .busy(busy)
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of addsub32: returns {overflow, carry, negative, c}.
    function automatic logic [34:0] addsub(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] aluc);
        longint sa, sb, r;
        logic [32:0] u;
        logic [31:0] c;
        logic ov;
        if (!aluc[1]) begin
            if (!aluc[0]) begin
                u = {1'b0, a} + {1'b0, b};
                return {1'b0, u[32], 1'b0, u[31:0]};
            end
            c = a - b;
            return {1'b0, (a < b), 1'b0, c};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = aluc[0] ? sa - sb : sa + sb;
        ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        c  = ov ? 32'h0 : r[31:0];
        return {ov, 1'b0, c[31], c};
    endfunction

    always_comb {au_overflow, au_carry, au_negative, au_c} = addsub(au_a, au_b, au_aluc);

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: one outstanding op, its age in cycles since grant, and tie priority.
    bit          m_out = 0;
    int          m_age = 0;
    bit          m_prio = 0;
    bit          m_g0 = 0, m_g1 = 0;
    bit          m_id = 0;
    logic [TAG_W-1:0] m_tag = '0;
    logic [34:0] m_res = '0;
    logic [65:0] m_au = '0;

    always @(negedge clk) begin
        if (en) begin
            m_g0 = 0;
            m_g1 = 0;
            if (!m_out) begin
                if (r0_valid && r1_valid) begin
                    m_g0 = !m_prio;
                    m_g1 = m_prio;
                end else begin
                    m_g0 = r0_valid;
                    m_g1 = r1_valid;
                end
            end
            chk("m_ready", {70'd0, r0_ready, r1_ready}, {70'd0, m_g0, m_g1});
            chk("m_busy", {71'd0, busy}, {71'd0, m_out});
            chk("m_rsp_valid", {71'd0, rsp_valid}, {71'd0, (m_out && m_age >= 1)});
            chk("m_au", {6'd0, au_aluc, au_a, au_b}, {6'd0, m_au});
            if (m_out && m_age >= 1)
                chk("m_rsp", {32'd0, rsp_id, rsp_tag, rsp_overflow, rsp_carry, rsp_negative, rsp_c},
                    {32'd0, m_id, m_tag, m_res});
        end
    end

    always @(posedge clk) begin
        if (en) begin
            if (rst) begin
                m_out = 0; m_age = 0; m_prio = 0; m_au = '0;
            end else if (m_out) begin
                if (m_age >= 1 && rsp_ready) m_out = 0;
                else m_age++;
            end else if (m_g0 || m_g1) begin
                m_out = 1;
                m_age = 0;
                m_id  = m_g1;
                m_tag = m_g1 ? r1_tag : r0_tag;
                m_au  = m_g1 ? {r1_aluc, r1_a, r1_b} : {r0_aluc, r0_a, r0_b};
                m_res = addsub(m_au[63:32], m_au[31:0], m_au[65:64]);
`ifndef ARB_FIXED_PRIO_EN
                m_prio = !m_g1;
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL rsp_timeout actual=0 required=1 t=%0t", $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, n;
        bit ids [4];
        logic [31:0] held;
        logic [3:0]  exp_ids;

        rst = 1'b1; rsp_ready = 1'b1;
        r0_valid = 0; r0_a = '0; r0_b = '0; r0_aluc = '0; r0_tag = '0;
        r1_valid = 0; r1_a = '0; r1_b = '0; r1_aluc = '0; r1_tag = '0;
        tick(); tick();
        en = 1;
        tick();
        rst = 1'b0;

        // Model pins: hand-computed unit arithmetic.
        chk("pin_uadd", {37'd0, addsub(32'hFFFFFFFF, 32'h1, 2'b00)}, {37'd0, 3'b010, 32'h0});
        chk("pin_sadd_ov", {37'd0, addsub(32'h7FFFFFFF, 32'h1, 2'b10)}, {37'd0, 3'b100, 32'h0});
        chk("pin_usub", {37'd0, addsub(32'h1, 32'h2, 2'b01)}, {37'd0, 3'b010, 32'hFFFFFFFF});

        // Reset state.
        chk("rst_rsp_valid", {71'd0, rsp_valid}, 72'd0);
        chk("rst_busy", {71'd0, busy}, 72'd0);
        chk("rst_au", {6'd0, au_aluc, au_a, au_b}, 72'd0);
        chk("rst_rsp_c", {40'd0, rsp_c}, 72'd0);

        // r0 alone: unsigned add wraps with carry.
        r0_valid = 1; r0_a = 32'hFFFFFFFF; r0_b = 32'h1; r0_aluc = 2'b00; r0_tag = 4'd3;
        #1;
        chk("t1_ready", {70'd0, r0_ready, r1_ready}, 72'b10);
        tick();
        r0_valid = 0;
        wait_rsp(cyc);
        chk("t1_latency", 72'(cyc), 72'd1);
        chk("t1_rsp", {32'd0, rsp_id, rsp_tag, rsp_overflow, rsp_carry, rsp_negative, rsp_c},
            {32'd0, 1'b0, 4'd3, 3'b010, 32'h0});
        tick();
        chk("t1_done_busy", {71'd0, busy}, 72'd0);

        // r1 alone: signed add overflow.
        r1_valid = 1; r1_a = 32'h7FFFFFFF; r1_b = 32'h1; r1_aluc = 2'b10; r1_tag = 4'd5;
        tick();
        r1_valid = 0;
        wait_rsp(cyc);
        chk("t2_rsp", {32'd0, rsp_id, rsp_tag, rsp_overflow, rsp_carry, rsp_negative, rsp_c},
            {32'd0, 1'b1, 4'd5, 3'b100, 32'h0});
        tick();

        // r0: unsigned sub with borrow.
        r0_valid = 1; r0_a = 32'h1; r0_b = 32'h2; r0_aluc = 2'b01; r0_tag = 4'd7;
        tick();
        r0_valid = 0;
        wait_rsp(cyc);
        chk("t3_rsp", {32'd0, rsp_id, rsp_tag, rsp_overflow, rsp_carry, rsp_negative, rsp_c},
            {32'd0, 1'b0, 4'd7, 3'b010, 32'hFFFFFFFF});
        tick();

        // Both requesters always valid: tie-break order.
        do_reset();
        r0_a = 32'd10; r0_b = 32'd3; r0_aluc = 2'b00; r0_tag = 4'd1;
        r1_a = 32'd20; r1_b = 32'd5; r1_aluc = 2'b01; r1_tag = 4'd2;
        r0_valid = 1; r1_valid = 1;
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            tick();
            if (rsp_valid === 1'b1) begin
                ids[n] = rsp_id;
                n++;
            end
        end
        r0_valid = 0; r1_valid = 0;
        chk("t4_count", 72'(n), 72'd4);
`ifdef ARB_FIXED_PRIO_EN
        exp_ids = 4'b0000;
`else
        exp_ids = 4'b0101;
`endif
        chk("t4_ids", {68'd0, ids[0], ids[1], ids[2], ids[3]}, {68'd0, exp_ids});
        repeat (4) tick();

        // Consumer stalls: response held, no grants.
        rsp_ready = 0;
        r0_valid = 1; r0_a = 32'd5; r0_b = 32'd9; r0_aluc = 2'b11; r0_tag = 4'd9;
        tick();
        r1_valid = 1;
        wait_rsp(cyc);
        held = rsp_c;
        chk("t5_value", {40'd0, rsp_c}, {40'd0, 32'hFFFFFFFC});
        for (int k = 0; k < 5; k++) begin
            chk("t5_stable", {40'd0, rsp_c}, {40'd0, held});
            chk("t5_hold", {68'd0, r0_ready, r1_ready, busy, rsp_valid}, 72'b0011);
            tick();
        end
        r0_valid = 0;
        rsp_ready = 1;
        #1;
        chk("t5_hs_no_grant", {71'd0, r1_ready}, 72'd0);
        tick();
        chk("t5_idle", {70'd0, busy, rsp_valid}, 72'd0);
        chk("t5_next_grant", {71'd0, r1_ready}, 72'd1);
        r1_valid = 0;
        repeat (2) tick();

        // Reset during EXEC drops the op and the tie priority.
        r0_valid = 1; r0_a = 32'd1; r0_b = 32'd1; r0_aluc = 2'b00; r0_tag = 4'd4;
        tick();
        r0_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("t6_after_rst", {70'd0, rsp_valid, busy}, 72'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t6_no_rsp", {71'd0, rsp_valid}, 72'd0);
        end
        r0_valid = 1; r1_valid = 1;
        #1;
        chk("t6_prio0", {70'd0, r0_ready, r1_ready}, 72'b10);
        tick();
        r0_valid = 0; r1_valid = 0;
        wait_rsp(cyc);
        chk("t6_id", {71'd0, rsp_id}, 72'd0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
